// File: rtl/mbinit_param_negotiator.sv
// MBINIT.PARAM exchange: send local config request, await the partner's
// response with timeout/retry, then negotiate and publish link parameters.
module mbinit_param_negotiator #(
    parameter int RATE_W      = 3,
    parameter int VSWING_W    = 5,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 8000,
    parameter int TO_W        = 16
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                i_start_en,
    input  logic                i_busy_sideband,
    input  logic                i_falling_edge_busy,
    input  logic [3:0]          i_rx_msg,
    input  logic                i_msg_valid,
    input  logic [RATE_W-1:0]   i_rx_max_rate,
    input  logic                i_rx_clock_mode,
    input  logic                i_rx_phase_clock,
    input  logic [VSWING_W-1:0] i_local_vswing,
    input  logic [RATE_W-1:0]   i_local_max_rate,
    input  logic                i_local_clock_mode,
    input  logic                i_local_phase_clock,
    output logic [3:0]          o_tx_msg,
    output logic                o_tx_valid,
    output logic [VSWING_W-1:0] o_tx_vswing,
    output logic [RATE_W-1:0]   o_tx_max_rate,
    output logic                o_tx_clock_mode,
    output logic                o_tx_phase_clock,
    output logic [RATE_W-1:0]   o_final_max_rate,
    output logic                o_final_clock_mode,
    output logic                o_final_phase_clock,
    output logic                o_done,
    output logic                o_train_error_req,
    output logic [1:0]          o_retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_REQ, S_WAIT, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      RMAX    = 8'(MAX_RETRY);

    state_t              state, nxt;
    logic [TO_W-1:0]     timer;
    logic [7:0]          retry_cnt, retry_nxt;
    logic [RATE_W-1:0]   cap_rate;
    logic                cap_mode, cap_phase;
    logic                resp_hit, to_hit, chk_ok;

    assign resp_hit = i_msg_valid && (i_rx_msg == 4'b0010);
    assign to_hit   = (timer == TO_LAST);
    assign chk_ok   = (cap_rate != '0) && (cap_rate <= i_local_max_rate)
                      && (cap_mode == i_local_clock_mode);

    always_comb begin
        nxt       = state;
        retry_nxt = retry_cnt;
        if (!i_start_en) begin
            nxt       = S_IDLE;
            retry_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    nxt       = S_ARM;
                    retry_nxt = '0;
                end
                S_ARM:   if (!i_busy_sideband) nxt = S_REQ;
                S_REQ:   if (i_falling_edge_busy) nxt = S_WAIT;
                S_WAIT: begin
                    // A response arriving on the timeout cycle takes priority
                    if (resp_hit) begin
                        nxt = S_CHECK;
                    end else if (to_hit) begin
                        if (retry_cnt < RMAX) begin
                            retry_nxt = retry_cnt + 8'd1;
                            nxt       = S_ARM;
                        end else begin
                            nxt = S_ERROR;
                        end
                    end
                end
                S_CHECK: nxt = chk_ok ? S_DONE : S_ERROR;
                S_DONE:  nxt = S_DONE;
                S_ERROR: nxt = S_ERROR;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            retry_cnt  <= '0;
            cap_rate   <= '0;
            cap_mode   <= 1'b0;
            cap_phase  <= 1'b0;
        end else begin
            state     <= nxt;
            retry_cnt <= retry_nxt;
            if (state == S_WAIT && nxt == S_WAIT)
                timer <= timer + TO_W'(1);
            else
                timer <= '0;
            if (state == S_WAIT && resp_hit && i_start_en) begin
                cap_rate  <= i_rx_max_rate;
                cap_mode  <= i_rx_clock_mode;
                cap_phase <= i_rx_phase_clock;
            end
        end
    end

    // Outputs are registered from the next state
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_msg            <= '0;
            o_tx_valid          <= 1'b0;
            o_tx_vswing         <= '0;
            o_tx_max_rate       <= '0;
            o_tx_clock_mode     <= 1'b0;
            o_tx_phase_clock    <= 1'b0;
            o_final_max_rate    <= '0;
            o_final_clock_mode  <= 1'b0;
            o_final_phase_clock <= 1'b0;
            o_done              <= 1'b0;
            o_train_error_req   <= 1'b0;
            o_retry_cnt         <= '0;
        end else begin
            o_tx_valid       <= (nxt == S_REQ);
            o_tx_msg         <= (nxt == S_REQ) ? 4'b0001 : 4'b0000;
            o_tx_vswing      <= (nxt == S_REQ) ? i_local_vswing : '0;
            o_tx_max_rate    <= (nxt == S_REQ) ? i_local_max_rate : '0;
            o_tx_clock_mode  <= (nxt == S_REQ) && i_local_clock_mode;
            o_tx_phase_clock <= (nxt == S_REQ) && i_local_phase_clock;
            o_done           <= (nxt == S_DONE);
            o_train_error_req <= (nxt == S_ERROR) && (state != S_ERROR);
            if (nxt == S_IDLE)
                o_retry_cnt <= '0;
            else
                o_retry_cnt <= (retry_nxt > 8'd3) ? 2'd3 : retry_nxt[1:0];
            // Final parameters change only on leaving CHECK
            if (state == S_CHECK && i_start_en) begin
                o_final_max_rate    <= chk_ok ? cap_rate : '0;
                o_final_clock_mode  <= chk_ok && cap_mode;
                o_final_phase_clock <= chk_ok && cap_phase;
            end
        end
    end

endmodule

// File: tb/tb_mbinit_param_negotiator.sv
// Directed + randomized bench for mbinit_param_negotiator against an
// outcome-level model of the PARAM exchange.
module tb_mbinit_param_negotiator;

    localparam int RATE_W      = 3;
    localparam int VSWING_W    = 5;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 8;
    localparam int TO_W        = 16;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                rst_n;
    logic                i_start_en, i_busy_sideband, i_falling_edge_busy;
    logic [3:0]          i_rx_msg;
    logic                i_msg_valid;
    logic [RATE_W-1:0]   i_rx_max_rate;
    logic                i_rx_clock_mode, i_rx_phase_clock;
    logic [VSWING_W-1:0] i_local_vswing;
    logic [RATE_W-1:0]   i_local_max_rate;
    logic                i_local_clock_mode, i_local_phase_clock;
    logic [3:0]          o_tx_msg;
    logic                o_tx_valid;
    logic [VSWING_W-1:0] o_tx_vswing;
    logic [RATE_W-1:0]   o_tx_max_rate;
    logic                o_tx_clock_mode, o_tx_phase_clock;
    logic [RATE_W-1:0]   o_final_max_rate;
    logic                o_final_clock_mode, o_final_phase_clock;
    logic                o_done, o_train_error_req;
    logic [1:0]          o_retry_cnt;

    mbinit_param_negotiator #(
        .RATE_W(RATE_W), .VSWING_W(VSWING_W), .MAX_RETRY(MAX_RETRY),
        .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
    ) dut (
        .CLK(CLK), .rst_n(rst_n),
        .i_start_en(i_start_en), .i_busy_sideband(i_busy_sideband),
        .i_falling_edge_busy(i_falling_edge_busy),
        .i_rx_msg(i_rx_msg), .i_msg_valid(i_msg_valid),
        .i_rx_max_rate(i_rx_max_rate), .i_rx_clock_mode(i_rx_clock_mode),
        .i_rx_phase_clock(i_rx_phase_clock),
        .i_local_vswing(i_local_vswing), .i_local_max_rate(i_local_max_rate),
        .i_local_clock_mode(i_local_clock_mode),
        .i_local_phase_clock(i_local_phase_clock),
        .o_tx_msg(o_tx_msg), .o_tx_valid(o_tx_valid),
        .o_tx_vswing(o_tx_vswing), .o_tx_max_rate(o_tx_max_rate),
        .o_tx_clock_mode(o_tx_clock_mode), .o_tx_phase_clock(o_tx_phase_clock),
        .o_final_max_rate(o_final_max_rate),
        .o_final_clock_mode(o_final_clock_mode),
        .o_final_phase_clock(o_final_phase_clock),
        .o_done(o_done), .o_train_error_req(o_train_error_req),
        .o_retry_cnt(o_retry_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_final = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] tx_bus();
        return {o_tx_valid, o_tx_msg, o_tx_vswing, o_tx_max_rate,
                o_tx_clock_mode, o_tx_phase_clock};
    endfunction

    function automatic logic [31:0] fin_bus();
        return {o_final_max_rate, o_final_clock_mode, o_final_phase_clock};
    endfunction

    task automatic set_local(input logic [VSWING_W-1:0] vs,
                             input logic [RATE_W-1:0] r,
                             input logic m, input logic p);
        i_local_vswing      = vs;
        i_local_max_rate    = r;
        i_local_clock_mode  = m;
        i_local_phase_clock = p;
    endtask

    task automatic wait_req(input int a);
        int n;
        n = 0;
        while (!o_tx_valid && n < 8) begin
            tick();
            n++;
        end
        chk("req_valid", o_tx_valid, 1);
        chk("req_fields", tx_bus(),
            {1'b1, 4'b0001, i_local_vswing, i_local_max_rate,
             i_local_clock_mode, i_local_phase_clock});
        chk("req_retry_cnt", o_retry_cnt, a);
    endtask

    task automatic send_done(input int fe_dly);
        for (int k = 1; k < fe_dly; k++) begin
            tick();
            chk("req_hold", o_tx_valid, 1);
        end
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        chk("req_clear", tx_bus(), 0);
    endtask

    // ratt: attempt index that gets a response (> MAX_RETRY = never)
    task automatic run_trial(input int ratt, input int rdly,
                             input logic [RATE_W-1:0] rr, input logic rm,
                             input logic rp, input int fe_dly,
                             input int bcyc, input bit keep);
        int  nreq;
        bit  ok;
        nreq = (ratt > MAX_RETRY) ? MAX_RETRY + 1 : ratt + 1;
        ok = (ratt <= MAX_RETRY) && (rr != 0) && (rr <= i_local_max_rate)
             && (rm == i_local_clock_mode);
        i_start_en = 1'b1;
        for (int a = 0; a < nreq; a++) begin
            i_busy_sideband = 1'b1;
            for (int b = 0; b < bcyc; b++) begin
                tick();
                chk("busy_hold", o_tx_valid, 0);
            end
            i_busy_sideband = 1'b0;
            wait_req(a);
            send_done(fe_dly);
            if (a == ratt) begin
                for (int j = 0; j < rdly; j++) begin
                    i_msg_valid = (j == 0);
                    i_rx_msg    = 4'($urandom_range(3, 15));
                    tick();
                    i_msg_valid = 1'b0;
                end
                i_msg_valid      = 1'b1;
                i_rx_msg         = 4'b0010;
                i_rx_max_rate    = rr;
                i_rx_clock_mode  = rm;
                i_rx_phase_clock = rp;
                tick();
                i_msg_valid      = 1'b0;
                i_rx_max_rate    = 3'($urandom);
                chk("check_quiet", {o_done, o_train_error_req}, 0);
                tick();
                exp_final = ok ? {rr, rm, rp} : 5'd0;
                chk("outcome", {o_done, o_train_error_req}, {ok, !ok});
                chk("final", fin_bus(), exp_final);
                tick();
                chk("outcome_hold", {o_done, o_train_error_req}, {ok, 1'b0});
                chk("retry_end", o_retry_cnt, a);
            end else begin
                i_msg_valid = 1'b1;
                i_rx_msg    = 4'($urandom_range(3, 15));
                tick();
                i_msg_valid = 1'b0;
                for (int j = 1; j < TIMEOUT_CYC - 1; j++) tick();
                chk("no_early_timeout", {o_train_error_req, o_tx_valid}, 0);
                tick();
                if (a == MAX_RETRY) begin
                    chk("timeout_error", {o_train_error_req, o_done}, 2'b10);
                    chk("retry_max", o_retry_cnt, MAX_RETRY);
                    tick();
                    chk("error_pulse_once", o_train_error_req, 0);
                end
            end
        end
        if (!keep) begin
            i_start_en = 1'b0;
            tick();
            chk("abort_clear", {o_done, o_tx_valid, o_retry_cnt,
                                o_train_error_req}, 0);
            chk("final_hold", fin_bus(), exp_final);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_start_en = 0; i_busy_sideband = 0; i_falling_edge_busy = 0;
        i_rx_msg = 0; i_msg_valid = 0; i_rx_max_rate = 0;
        i_rx_clock_mode = 0; i_rx_phase_clock = 0;
        set_local(5'h0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_tx", tx_bus(), 0);
        chk("reset_misc", {fin_bus(), o_done, o_train_error_req,
                           o_retry_cnt}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_quiet", {tx_bus(), o_done}, 0);

        set_local(5'h15, 3'd4, 1'b0, 1'b0);
        run_trial(0, 2, 3'd3, 1'b0, 1'b1, 3, 0, 0);
        run_trial(3, 0, 3'd0, 1'b0, 1'b0, 2, 1, 0);
        run_trial(0, 1, 3'd5, 1'b0, 1'b1, 1, 0, 0);
        run_trial(1, 0, 3'd2, 1'b1, 1'b0, 2, 2, 0);
        run_trial(2, TIMEOUT_CYC - 1, 3'd2, 1'b0, 1'b1, 1, 0, 0);
        run_trial(0, 3, 3'd0, 1'b0, 1'b0, 2, 0, 0);

        // abort during the second wait, then a fresh run
        i_start_en = 1'b1;
        wait_req(0);
        send_done(2);
        for (int j = 0; j < TIMEOUT_CYC; j++) tick();
        wait_req(1);
        send_done(1);
        tick();
        tick();
        i_start_en = 1'b0;
        tick();
        chk("mid_abort", {o_retry_cnt, o_tx_valid, o_train_error_req}, 0);
        run_trial(0, 0, 3'd4, 1'b0, 1'b0, 2, 1, 0);

        // asynchronous reset while in DONE
        set_local(5'h0a, 3'd7, 1'b1, 1'b1);
        run_trial(1, 4, 3'd6, 1'b1, 1'b1, 2, 0, 1);
        chk("done_before_rst", o_done, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {fin_bus(), o_done, o_retry_cnt, tx_bus()}, 0);
        @(negedge CLK);
        i_start_en = 1'b0;
        rst_n = 1'b1;
        exp_final = '0;
        tick();
        chk("post_rst_idle", {o_done, o_tx_valid}, 0);

        for (int t = 0; t < 25; t++) begin
            set_local(5'($urandom), 3'($urandom_range(1, 7)),
                      1'($urandom), 1'($urandom));
            run_trial($urandom_range(0, MAX_RETRY + 1),
                      $urandom_range(0, TIMEOUT_CYC - 1),
                      3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(1, 4), $urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
